// File: rtl/rgb_indicator_multi.sv
// rgb_indicator_multi: per-player RGB status driver for the reaction-time tester.
// Maps the StateMachine state onto one RGB LED per player (2..4 players), with a
// blink prescaler, PWM dimming and a registered winner/tie decision in COMPARE.
// Optional macro RGB_BREATHE_EN: the IDLE white of the current player breathes
// (triangle duty ramp) instead of using the fixed DIM_DUTY.
module rgb_indicator_multi #(
    parameter int N_PLAYERS  = 2,
    parameter int TIME_W     = 10,
    parameter int TURN_W     = 3,
    parameter int MAX_TURN   = 7,
    parameter int CLK_HZ     = 12000000,
    parameter int BLINK_HZ   = 2,
    parameter int PWM_W      = 4,
    parameter int DIM_DUTY   = 4,
    parameter int ACTIVE_LOW = 1,
    localparam int PW        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PW-1:0]                 cur_player,
    input  logic [2:0]                    machine_state,
    input  logic [N_PLAYERS*TURN_W-1:0]   test_turn,
    input  logic [N_PLAYERS*TIME_W-1:0]   avr_react_time,
    output logic [N_PLAYERS*3-1:0]        rgb,
    output logic [PW-1:0]                 winner,
    output logic                          winner_valid,
    output logic                          tie
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_CLR_CNT1 = 3'd2,
        ST_START    = 3'd3,
        ST_STORAGE  = 3'd4,
        ST_CLR_CNT2 = 3'd5,
        ST_AVERAGE  = 3'd6,
        ST_COMPARE  = 3'd7
    } state_e;

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [N_PLAYERS*3-1:0] RGB_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    state_e                  state_s;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [PWM_W-1:0]        pwm_cnt_q;
    logic [2:0]              prev_state_q;
    logic [PW-1:0]           winner_q, winner_d;
    logic                    valid_q, valid_d;
    logic                    tie_q, tie_d;
    logic [N_PLAYERS-1:0]    min_mask_q, min_mask_d;
    logic [N_PLAYERS*3-1:0]  rgb_q, rgb_d;

    logic [TIME_W-1:0]       min_s;
    logic [N_PLAYERS-1:0]    mask_s;
    logic [PW-1:0]           win_s;
    logic                    tie_s;
    logic                    entry_s;
    logic                    cp_valid_s;
    logic                    dim_on_s;
    logic                    white_on_s;
    logic [N_PLAYERS-1:0]    cmp_mask_s;
    logic                    cmp_tie_s;

    assign state_s    = state_e'(machine_state);
    assign entry_s    = (machine_state == 3'd7) && (prev_state_q != 3'd7);
    assign cp_valid_s = (32'(cur_player) < N_PLAYERS);
    assign dim_on_s   = (pwm_cnt_q < PWM_W'(DIM_DUTY));

`ifdef RGB_BREATHE_EN
    localparam int STEP = (CLK_HZ / 64 > 1) ? CLK_HZ / 64 : 1;
    localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int FULL = 2 ** PWM_W;

    logic [SW-1:0]  ramp_div_q;
    logic [PWM_W:0] duty_q;
    logic           dir_up_q;
    logic           idle_entry_s;

    assign idle_entry_s = (machine_state == 3'd0) && (prev_state_q != 3'd0);
    assign white_on_s   = ({1'b0, pwm_cnt_q} < duty_q);

    // Triangle duty ramp for the breathing IDLE white, restarted on IDLE entry.
    always_ff @(posedge clk) begin
        if (rst || idle_entry_s) begin
            ramp_div_q <= '0;
            duty_q     <= '0;
            dir_up_q   <= 1'b1;
        end else if (ramp_div_q == SW'(STEP - 1)) begin
            ramp_div_q <= '0;
            if (dir_up_q) begin
                if (duty_q == (PWM_W+1)'(FULL)) begin
                    dir_up_q <= 1'b0;
                    duty_q   <= duty_q - (PWM_W+1)'(1);
                end else begin
                    duty_q   <= duty_q + (PWM_W+1)'(1);
                end
            end else begin
                if (duty_q == (PWM_W+1)'(0)) begin
                    dir_up_q <= 1'b1;
                    duty_q   <= duty_q + (PWM_W+1)'(1);
                end else begin
                    duty_q   <= duty_q - (PWM_W+1)'(1);
                end
            end
        end else begin
            ramp_div_q <= ramp_div_q + SW'(1);
        end
    end
`else
    assign white_on_s = dim_on_s;
`endif

    // Minimum average, the set of players holding it, lowest index and tie flag.
    always_comb begin
        min_s  = '1;
        mask_s = '0;
        win_s  = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (avr_react_time[i*TIME_W +: TIME_W] < min_s) begin
                min_s = avr_react_time[i*TIME_W +: TIME_W];
            end else begin
                min_s = min_s;
            end
        end
        for (int i = 0; i < N_PLAYERS; i++) begin
            mask_s[i] = (avr_react_time[i*TIME_W +: TIME_W] == min_s);
        end
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (mask_s[i]) begin
                win_s = PW'(i);
            end else begin
                win_s = win_s;
            end
        end
        tie_s = |(mask_s & (mask_s - N_PLAYERS'(1)));
    end

    // Decision values: captured on COMPARE entry, frozen inside, cleared on exit.
    always_comb begin
        winner_d   = winner_q;
        valid_d    = valid_q;
        tie_d      = tie_q;
        min_mask_d = min_mask_q;
        if (entry_s) begin
            winner_d   = win_s;
            valid_d    = 1'b1;
            tie_d      = tie_s;
            min_mask_d = mask_s;
        end else if (machine_state != 3'd7) begin
            valid_d    = 1'b0;
            tie_d      = 1'b0;
        end else begin
            valid_d    = valid_q;
        end
        cmp_mask_s = entry_s ? mask_s : min_mask_q;
        cmp_tie_s  = entry_s ? tie_s : tie_q;
    end

    // Blink prescaler next state: count 0..HALF-1, toggle the phase on wrap.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BW'(HALF - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_phase_d = blink_phase_q;
        end
    end

    // Colour map for every LED, gated by the current PWM and blink phase.
    always_comb begin
        rgb_d = '0;
        if (machine_state == 3'd7) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (cmp_mask_s[i]) begin
                    rgb_d[i*3 +: 3] = cmp_tie_s ? 3'b110 : 3'b010;
                end else begin
                    rgb_d[i*3 +: 3] = 3'b100;
                end
            end
        end else if (cp_valid_s) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (cur_player == PW'(i)) begin
                    case (state_s)
                        ST_IDLE:     rgb_d[i*3 +: 3] = white_on_s ? 3'b111 : 3'b000;
                        ST_WAIT,
                        ST_CLR_CNT1: rgb_d[i*3 +: 3] = 3'b100;
                        ST_START:    rgb_d[i*3 +: 3] = 3'b010;
                        ST_STORAGE,
                        ST_CLR_CNT2: rgb_d[i*3 +: 3] = blink_phase_q ? 3'b001 : 3'b000;
                        ST_AVERAGE:  rgb_d[i*3 +: 3] = 3'b011;
                        default:     rgb_d[i*3 +: 3] = 3'b000;
                    endcase
                end else if ((test_turn[i*TURN_W +: TURN_W] == TURN_W'(MAX_TURN)) && dim_on_s) begin
                    rgb_d[i*3 +: 3] = 3'b011;
                end else begin
                    rgb_d[i*3 +: 3] = 3'b000;
                end
            end
        end else begin
            rgb_d = '0;
        end
    end

    // State registers: prescalers, previous state, decision and output colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pwm_cnt_q     <= '0;
            prev_state_q  <= 3'd0;
            winner_q      <= '0;
            valid_q       <= 1'b0;
            tie_q         <= 1'b0;
            min_mask_q    <= '0;
            rgb_q         <= RGB_OFF;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_q + PWM_W'(1);
            prev_state_q  <= machine_state;
            winner_q      <= winner_d;
            valid_q       <= valid_d;
            tie_q         <= tie_d;
            min_mask_q    <= min_mask_d;
            rgb_q         <= (ACTIVE_LOW != 0) ? ~rgb_d : rgb_d;
        end
    end

    assign rgb          = rgb_q;
    assign winner       = winner_q;
    assign winner_valid = valid_q;
    assign tie          = tie_q;

endmodule
